// File: rtl/param_nr_divider_if.sv
// Start/done handshake and operand/result bundle for param_nr_divider.
// The master drives the request; the slave (the divider) returns results and status.
interface param_nr_divider_if #(
    parameter int P_WIDTH = 32
);
    logic               start;
    logic               signed_in;
    logic [P_WIDTH-1:0] dividend_in;
    logic [P_WIDTH-1:0] divisor_in;
    logic [P_WIDTH-1:0] quotient_out;
    logic [P_WIDTH-1:0] remainder_out;
    logic               done;
    logic               busy;
    logic               div_by_zero;
    logic               overflow;

    modport master (
        output start, signed_in, dividend_in, divisor_in,
        input  quotient_out, remainder_out, done, busy, div_by_zero, overflow
    );

    modport slave (
        input  start, signed_in, dividend_in, divisor_in,
        output quotient_out, remainder_out, done, busy, div_by_zero, overflow
    );
endinterface

// File: rtl/param_nr_divider.sv
// Sequential non-restoring divider, one quotient bit per cycle, signed or unsigned.
// Divide-by-zero and signed MIN/-1 complete in a single cycle without iterating.
module param_nr_divider #(
    parameter int P_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    param_nr_divider_if.slave  div_if
);
    localparam int CNT_W = $clog2(P_WIDTH + 1);
    localparam logic [P_WIDTH-1:0] MIN_VAL = {1'b1, {(P_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t             state_reg, state_next;
    logic [P_WIDTH:0]   rem_reg, rem_next;
    logic [P_WIDTH-1:0] quo_reg, quo_next;
    logic [P_WIDTH-1:0] dvs_reg, dvs_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               q_neg_reg, q_neg_next;
    logic               r_neg_reg, r_neg_next;
    logic [P_WIDTH-1:0] quotient_reg, quotient_next;
    logic [P_WIDTH-1:0] remainder_reg, remainder_next;
    logic               done_reg, done_next;
    logic               busy_reg, busy_next;
    logic               dbz_reg, dbz_next;
    logic               ovf_reg, ovf_next;

    logic [P_WIDTH:0]   shifted;
    logic [P_WIDTH:0]   step_rem;
    logic [P_WIDTH-1:0] fixed_rem;
    logic               dvd_neg;
    logic               dvs_neg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rem_reg       <= '0;
            quo_reg       <= '0;
            dvs_reg       <= '0;
            cnt_reg       <= '0;
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            dbz_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rem_reg       <= rem_next;
            quo_reg       <= quo_next;
            dvs_reg       <= dvs_next;
            cnt_reg       <= cnt_next;
            q_neg_reg     <= q_neg_next;
            r_neg_reg     <= r_neg_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            done_reg      <= done_next;
            busy_reg      <= busy_next;
            dbz_reg       <= dbz_next;
            ovf_reg       <= ovf_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        rem_next       = rem_reg;
        quo_next       = quo_reg;
        dvs_next       = dvs_reg;
        cnt_next       = cnt_reg;
        q_neg_next     = q_neg_reg;
        r_neg_next     = r_neg_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        done_next      = 1'b0;
        busy_next      = busy_reg;
        dbz_next       = dbz_reg;
        ovf_next       = ovf_reg;

        dvd_neg = div_if.signed_in & div_if.dividend_in[P_WIDTH-1];
        dvs_neg = div_if.signed_in & div_if.divisor_in[P_WIDTH-1];

        // Partial remainder and dividend shift together as one double-width register.
        shifted  = {rem_reg[P_WIDTH-1:0], quo_reg[P_WIDTH-1]};
        step_rem = rem_reg[P_WIDTH] ? shifted + {1'b0, dvs_reg}
                                    : shifted - {1'b0, dvs_reg};
        // The corrected remainder lies in [0, divisor), so the low bits suffice.
        fixed_rem = rem_reg[P_WIDTH-1:0] + (rem_reg[P_WIDTH] ? dvs_reg : '0);

        case (state_reg)
            IDLE: begin
                if (div_if.start) begin
                    if (div_if.divisor_in == '0) begin
                        quotient_next  = '1;
                        remainder_next = div_if.dividend_in;
                        dbz_next       = 1'b1;
                        ovf_next       = 1'b0;
                        done_next      = 1'b1;
                    end else if (div_if.signed_in && div_if.dividend_in == MIN_VAL &&
                                 div_if.divisor_in == '1) begin
                        quotient_next  = MIN_VAL;
                        remainder_next = '0;
                        dbz_next       = 1'b0;
                        ovf_next       = 1'b1;
                        done_next      = 1'b1;
                    end else begin
                        // Magnitude of MIN is 2^(P_WIDTH-1), which still fits unsigned.
                        rem_next   = '0;
                        quo_next   = dvd_neg ? -div_if.dividend_in : div_if.dividend_in;
                        dvs_next   = dvs_neg ? -div_if.divisor_in  : div_if.divisor_in;
                        q_neg_next = dvd_neg ^ dvs_neg;
                        r_neg_next = dvd_neg;
                        cnt_next   = CNT_W'(P_WIDTH);
                        busy_next  = 1'b1;
                        state_next = ITER;
                    end
                end
            end
            ITER: begin
                rem_next = step_rem;
                quo_next = {quo_reg[P_WIDTH-2:0], ~step_rem[P_WIDTH]};
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                quotient_next  = q_neg_reg ? -quo_reg : quo_reg;
                remainder_next = r_neg_reg ? -fixed_rem : fixed_rem;
                dbz_next       = 1'b0;
                ovf_next       = 1'b0;
                done_next      = 1'b1;
                busy_next      = 1'b0;
                state_next     = IDLE;
            end
            default: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    assign div_if.quotient_out  = quotient_reg;
    assign div_if.remainder_out = remainder_reg;
    assign div_if.done          = done_reg;
    assign div_if.busy          = busy_reg;
    assign div_if.div_by_zero   = dbz_reg;
    assign div_if.overflow      = ovf_reg;
endmodule
